// File: rtl/tlk2711_dma_wr_if.sv
// Bus bundle for the TLK2711 RX write-DMA stage.
// Groups the command req/ack channel, the 64-bit ingress stream and the
// AXI4 write-address / write-data / write-response channels.
//   master : view taken by tlk2711_dma_wr (drives ack, stream ready, AXI AW/W, bready)
//   slave  : view taken by the environment (command source, stream source, AXI slave)
interface tlk2711_dma_wr_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DLEN_WIDTH  = 16,
  parameter int DATA_WIDTH  = 64,
  parameter int WBYTE_WIDTH = 8
) ();

  // command channel: {addr, byte len}
  logic                             i_wr_cmd_req;
  logic                             o_wr_cmd_ack;
  logic [ADDR_WIDTH+DLEN_WIDTH-1:0] i_wr_cmd_data;

  // ingress data stream
  logic                             o_dma_wr_ready;
  logic                             i_dma_wr_valid;
  logic [DATA_WIDTH-1:0]            i_dma_wr_data;
  logic [WBYTE_WIDTH-1:0]           i_dma_wr_keep;

  // AXI4 write address
  logic [ADDR_WIDTH-1:0]            m_axi_awaddr;
  logic [7:0]                       m_axi_awlen;
  logic [2:0]                       m_axi_awsize;
  logic [1:0]                       m_axi_awburst;
  logic                             m_axi_awvalid;
  logic                             m_axi_awready;

  // AXI4 write data
  logic [DATA_WIDTH-1:0]            m_axi_wdata;
  logic [WBYTE_WIDTH-1:0]           m_axi_wstrb;
  logic                             m_axi_wlast;
  logic                             m_axi_wvalid;
  logic                             m_axi_wready;

  // AXI4 write response
  logic [1:0]                       m_axi_bresp;
  logic                             m_axi_bvalid;
  logic                             m_axi_bready;

  modport master (
    input  i_wr_cmd_req, i_wr_cmd_data,
    output o_wr_cmd_ack,
    output o_dma_wr_ready,
    input  i_dma_wr_valid, i_dma_wr_data, i_dma_wr_keep,
    output m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bresp, m_axi_bvalid,
    output m_axi_bready
  );

  modport slave (
    output i_wr_cmd_req, i_wr_cmd_data,
    input  o_wr_cmd_ack,
    input  o_dma_wr_ready,
    output i_dma_wr_valid, i_dma_wr_data, i_dma_wr_keep,
    input  m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready
  );

endinterface

// File: rtl/tlk2711_dma_wr.sv
// AXI4 write master downstream of the TLK2711 RX link.
// Accepts one {addr, byte len} command at a time, splits it into INCR bursts
// (at most MAX_BURST beats, never crossing a 4 KB page, one burst in flight),
// forwards the 64-bit stream into the W channel through a one-entry register
// stage and pulses o_wr_finish once the last burst's B response is in.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   i_soft_rst    graceful abort: open AXI handshakes are completed, remaining
//                 beats of the current burst go out with wstrb=0, no finish
//   o_wr_finish   1-cycle pulse, command fully written and acknowledged
//   o_wr_err      sticky, set by any non-OKAY bresp
//   bus           tlk2711_dma_wr_if.master (command, stream, AXI AW/W/B)
module tlk2711_dma_wr #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DLEN_WIDTH  = 16,
  parameter int DATA_WIDTH  = 64,
  parameter int WBYTE_WIDTH = 8,
  parameter int MAX_BURST   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_soft_rst,
  output logic               o_wr_finish,
  output logic               o_wr_err,
  tlk2711_dma_wr_if.master   bus
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LOG2B = $clog2(BYTES);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AW   = 3'd1,
    DATA = 3'd2,
    RESP = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   addr;        // start address of the current burst
  logic [DLEN_WIDTH-1:0]   remaining;   // beats not yet covered by a completed burst
  logic [8:0]              bsize;       // beats in the current burst
  logic [8:0]              issued;      // beats loaded into the W stage this burst
  logic                    abort;       // soft reset seen while a burst is open

  logic                    cmd_ack;
  logic                    aw_valid;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]              aw_len;
  logic                    w_valid;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [WBYTE_WIDTH-1:0]  w_strb;
  logic                    w_last;
  logic                    b_ready;
  logic                    finish;
  logic                    err;

  logic [ADDR_WIDTH-1:0]   cmd_addr;
  logic [DLEN_WIDTH-1:0]   cmd_beats;
  logic [8:0]              cmd_size;
  logic [8:0]              cmd_len_m1;
  logic [ADDR_WIDTH-1:0]   next_addr;
  logic [DLEN_WIDTH-1:0]   next_remaining;
  logic [8:0]              next_size;
  logic [8:0]              next_len_m1;
  logic                    w_room;
  logic                    beat_slot;
  logic                    zero_beat;
  logic                    load;
  logic                    stream_ready;

  // Beats in the next burst: bounded by what is left, MAX_BURST and the 4 KB page end.
  function automatic logic [8:0] burst_size(input logic [ADDR_WIDTH-1:0] a,
                                            input logic [DLEN_WIDTH-1:0] rem);
    logic [31:0] to_4k;
    logic [31:0] n;
    to_4k = (32'd4096 - {20'd0, a[11:0]}) >> LOG2B;
    n     = {{(32-DLEN_WIDTH){1'b0}}, rem};
    if (to_4k < n) n = to_4k;
    if (32'(MAX_BURST) < n) n = 32'(MAX_BURST);
    return n[8:0];
  endfunction

  // Command decode, next-burst arithmetic and W-stage load decision.
  always_comb begin
    cmd_addr       = {bus.i_wr_cmd_data[ADDR_WIDTH+DLEN_WIDTH-1:DLEN_WIDTH+LOG2B], {LOG2B{1'b0}}};
    cmd_beats      = bus.i_wr_cmd_data[DLEN_WIDTH-1:0] >> LOG2B;
    cmd_size       = burst_size(cmd_addr, cmd_beats);
    cmd_len_m1     = cmd_size - 9'd1;
    next_addr      = addr + (ADDR_WIDTH'(bsize) << LOG2B);
    next_remaining = remaining - DLEN_WIDTH'(bsize);
    next_size      = burst_size(next_addr, next_remaining);
    next_len_m1    = next_size - 9'd1;
    // the W register can take a beat when empty or draining this cycle
    w_room         = ~w_valid | bus.m_axi_wready;
    beat_slot      = (state == DATA) & w_room & (issued < bsize);
    // once aborting, the burst is padded with null beats instead of stream data
    zero_beat      = abort | i_soft_rst;
    load           = beat_slot & (zero_beat | bus.i_dma_wr_valid);
    stream_ready   = beat_slot & ~zero_beat;
  end

  // Command FSM with registered AXI / handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      bsize     <= 9'd0;
      issued    <= 9'd0;
      abort     <= 1'b0;
      cmd_ack   <= 1'b0;
      aw_valid  <= 1'b0;
      aw_addr   <= '0;
      aw_len    <= 8'd0;
      w_valid   <= 1'b0;
      w_data    <= '0;
      w_strb    <= '0;
      w_last    <= 1'b0;
      b_ready   <= 1'b0;
      finish    <= 1'b0;
      err       <= 1'b0;
    end else begin
      cmd_ack <= 1'b0;
      case (state)
        IDLE: begin
          finish <= 1'b0;
          if (i_soft_rst) begin
            err <= 1'b0;
          end else if (bus.i_wr_cmd_req) begin
            cmd_ack   <= 1'b1;
            addr      <= cmd_addr;
            remaining <= cmd_beats;
            if (cmd_beats == '0) begin
              state <= DONE;
            end else begin
              state    <= AW;
              aw_valid <= 1'b1;
              aw_addr  <= cmd_addr;
              bsize    <= cmd_size;
              aw_len   <= cmd_len_m1[7:0];
            end
          end
        end

        AW: begin
          if (i_soft_rst) begin
            abort <= 1'b1;
            err   <= 1'b0;
          end
          if (aw_valid && bus.m_axi_awready) begin
            aw_valid <= 1'b0;
            issued   <= 9'd0;
            state    <= DATA;
          end
        end

        DATA: begin
          if (i_soft_rst) begin
            abort <= 1'b1;
            err   <= 1'b0;
          end
          if (w_valid && bus.m_axi_wready) begin
            w_valid <= 1'b0;
          end
          if (load) begin
            w_valid <= 1'b1;
            w_data  <= zero_beat ? '0 : bus.i_dma_wr_data;
            w_strb  <= zero_beat ? '0 : bus.i_dma_wr_keep;
            w_last  <= (issued == bsize - 9'd1);
            issued  <= issued + 9'd1;
          end
          if (w_valid && bus.m_axi_wready && w_last) begin
            state   <= RESP;
            b_ready <= 1'b1;
          end
        end

        RESP: begin
          if (i_soft_rst) begin
            abort <= 1'b1;
            err   <= 1'b0;
          end
          if (bus.m_axi_bvalid && b_ready) begin
            b_ready <= 1'b0;
            if (zero_beat) begin
              abort <= 1'b0;
              state <= IDLE;
            end else begin
              if (bus.m_axi_bresp != 2'b00) err <= 1'b1;
              addr      <= next_addr;
              remaining <= next_remaining;
              if (next_remaining == '0) begin
                state  <= DONE;
                finish <= 1'b1;
              end else begin
                state    <= AW;
                aw_valid <= 1'b1;
                aw_addr  <= next_addr;
                bsize    <= next_size;
                aw_len   <= next_len_m1[7:0];
              end
            end
          end
        end

        DONE: begin
          // finish is already high when arriving from RESP; a zero-length
          // command arrives with it low and raises it here for one cycle
          if (i_soft_rst) begin
            finish <= 1'b0;
            err    <= 1'b0;
            state  <= IDLE;
          end else if (finish) begin
            finish <= 1'b0;
            state  <= IDLE;
          end else begin
            finish <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_wr_cmd_ack   = cmd_ack;
  assign bus.o_dma_wr_ready = stream_ready;
  assign bus.m_axi_awaddr   = aw_addr;
  assign bus.m_axi_awlen    = aw_len;
  assign bus.m_axi_awsize   = 3'(LOG2B);
  assign bus.m_axi_awburst  = 2'b01;
  assign bus.m_axi_awvalid  = aw_valid;
  assign bus.m_axi_wdata    = w_data;
  assign bus.m_axi_wstrb    = w_strb;
  assign bus.m_axi_wlast    = w_last;
  assign bus.m_axi_wvalid   = w_valid;
  assign bus.m_axi_bready   = b_ready;
  assign o_wr_finish        = finish;
  assign o_wr_err           = err;

endmodule

// File: tb/tb_tlk2711_dma_wr.sv
// Self-checking bench for tlk2711_dma_wr: random AXI slave back-pressure,
// random stream gaps, and a reference model that plans bursts from the
// command with plain arithmetic (page room, MAX_BURST, remaining beats).
module tb_tlk2711_dma_wr;

  localparam int AW_W = 32;
  localparam int DL_W = 16;
  localparam int D_W  = 64;
  localparam int WB_W = 8;
  localparam int MB   = 16;

  typedef struct { logic [31:0] addr; logic [7:0] len; logic [2:0] size; logic [1:0] burst; } aw_t;
  typedef struct { logic [63:0] data; logic [7:0] strb; logic last; } w_t;
  typedef struct { logic [63:0] data; logic [7:0] keep; } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic soft_rst = 1'b0;
  logic finish;
  logic err;

  int cyc = 0;
  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;
  bit stall = 1'b0;
  bit slverr_next = 1'b0;
  int b_pending = 0;
  bit stream_fire = 1'b0;
  bit b_fire = 1'b0;

  aw_t   aw_q[$];
  w_t    w_q[$];
  int    ack_cyc[$];
  int    fin_cyc[$];
  int    b_cyc[$];
  aw_t   exp_aw[$];
  w_t    exp_w[$];
  beat_t src_q[$];

  tlk2711_dma_wr_if #(.ADDR_WIDTH(AW_W), .DLEN_WIDTH(DL_W), .DATA_WIDTH(D_W), .WBYTE_WIDTH(WB_W)) bus ();

  tlk2711_dma_wr #(.ADDR_WIDTH(AW_W), .DLEN_WIDTH(DL_W), .DATA_WIDTH(D_W),
                   .WBYTE_WIDTH(WB_W), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .i_soft_rst(soft_rst),
    .o_wr_finish(finish), .o_wr_err(err), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor: handshakes seen here complete at the following rising edge
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.m_axi_awvalid && bus.m_axi_awready)
        aw_q.push_back('{bus.m_axi_awaddr, bus.m_axi_awlen, bus.m_axi_awsize, bus.m_axi_awburst});
      if (bus.m_axi_wvalid && bus.m_axi_wready) begin
        w_q.push_back('{bus.m_axi_wdata, bus.m_axi_wstrb, bus.m_axi_wlast});
        if (bus.m_axi_wlast) b_pending++;
      end
      if (bus.m_axi_bvalid && bus.m_axi_bready) b_cyc.push_back(cyc);
      if (bus.o_wr_cmd_ack) ack_cyc.push_back(cyc);
      if (finish) fin_cyc.push_back(cyc);
    end
    b_fire      = bus.m_axi_bvalid && bus.m_axi_bready;
    stream_fire = bus.i_dma_wr_valid && bus.o_dma_wr_ready;
  end

  // AXI slave: random ready, one B per completed burst
  initial begin
    bus.m_axi_awready = 1'b0;
    bus.m_axi_wready  = 1'b0;
    bus.m_axi_bvalid  = 1'b0;
    bus.m_axi_bresp   = 2'b00;
    forever begin
      @(posedge clk);
      #1;
      bus.m_axi_awready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.m_axi_wready  = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (b_fire) bus.m_axi_bvalid = 1'b0;
      if (!bus.m_axi_bvalid && b_pending > 0 && (!stall || $urandom_range(0, 1) == 1)) begin
        bus.m_axi_bvalid = 1'b1;
        bus.m_axi_bresp  = slverr_next ? 2'b10 : 2'b00;
        slverr_next      = 1'b0;
        b_pending--;
      end
    end
  end

  // stream source: valid only while ready, optional gaps
  initial begin
    bus.i_dma_wr_valid = 1'b0;
    bus.i_dma_wr_data  = '0;
    bus.i_dma_wr_keep  = '0;
    forever begin
      @(posedge clk);
      if (stream_fire) void'(src_q.pop_front());
      #2;
      if (src_q.size() > 0 && bus.o_dma_wr_ready && (!stall || $urandom_range(0, 2) != 0)) begin
        bus.i_dma_wr_valid = 1'b1;
        bus.i_dma_wr_data  = src_q[0].data;
        bus.i_dma_wr_keep  = src_q[0].keep;
      end else begin
        bus.i_dma_wr_valid = 1'b0;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: run still active at %0t, required finished", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int qcount(input int which);
    case (which)
      0: return ack_cyc.size();
      1: return fin_cyc.size();
      2: return b_cyc.size();
      default: return w_q.size();
    endcase
  endfunction

  task automatic wait_cnt(input string tag, input int which, input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (qcount(which) >= n) return;
    end
    chk(tag, qcount(which), n);
  endtask

  task automatic clear_mon();
    aw_q.delete(); w_q.delete(); ack_cyc.delete(); fin_cyc.delete(); b_cyc.delete();
    exp_aw.delete(); exp_w.delete();
  endtask

  // reference: split into bursts by page room / MAX_BURST / remaining beats
  task automatic plan_cmd(input logic [31:0] addr, input logic [15:0] len);
    int beats;
    longint a;
    beats = int'(len) / 8;
    a     = longint'(addr) & 64'hFFFF_FFF8;
    while (beats > 0) begin
      int room;
      int n;
      room = (4096 - int'(a % 4096)) / 8;
      n = beats;
      if (n > MB) n = MB;
      if (n > room) n = room;
      exp_aw.push_back('{a[31:0], 8'(n - 1), 3'd3, 2'd1});
      for (int k = 0; k < n; k++) begin
        beat_t b;
        b.data = {$urandom, $urandom};
        b.keep = 8'($urandom_range(0, 255));
        src_q.push_back(b);
        exp_w.push_back('{b.data, b.keep, (k == n - 1)});
      end
      a     = a + longint'(n * 8);
      beats = beats - n;
    end
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_aw_count"}, aw_q.size(), exp_aw.size());
    for (int i = 0; i < aw_q.size() && i < exp_aw.size(); i++) begin
      chk({tag, "_awaddr"},  aw_q[i].addr,  exp_aw[i].addr);
      chk({tag, "_awlen"},   aw_q[i].len,   exp_aw[i].len);
      chk({tag, "_awsize"},  aw_q[i].size,  exp_aw[i].size);
      chk({tag, "_awburst"}, aw_q[i].burst, exp_aw[i].burst);
    end
    chk({tag, "_b_count"}, b_cyc.size(), exp_aw.size());
    chk({tag, "_w_count"}, w_q.size(), exp_w.size());
    for (int i = 0; i < w_q.size() && i < exp_w.size(); i++) begin
      chk({tag, "_wdata"}, w_q[i].data, exp_w[i].data);
      chk({tag, "_wstrb"}, w_q[i].strb, exp_w[i].strb);
      chk({tag, "_wlast"}, w_q[i].last, exp_w[i].last);
    end
  endtask

  task automatic run_cmd(input string tag, input logic [31:0] addr, input logic [15:0] len, input logic exp_err);
    int rc;
    clear_mon();
    plan_cmd(addr, len);
    @(posedge clk);
    #1;
    bus.i_wr_cmd_req  = 1'b1;
    bus.i_wr_cmd_data = {addr, len};
    rc = cyc;
    wait_cnt({tag, "_ack_timeout"}, 0, 1, 20);
    @(posedge clk);
    #1;
    bus.i_wr_cmd_req = 1'b0;
    wait_cnt({tag, "_fin_timeout"}, 1, 1, 4000);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk({tag, "_ack_count"}, ack_cyc.size(), 1);
    if (ack_cyc.size() > 0) chk({tag, "_ack_latency"}, ack_cyc[0], rc + 1);
    chk({tag, "_fin_count"}, fin_cyc.size(), 1);
    if (fin_cyc.size() > 0) begin
      if (exp_aw.size() == 0) chk({tag, "_fin_latency"}, fin_cyc[0], rc + 2);
      else if (b_cyc.size() > 0) chk({tag, "_fin_latency"}, fin_cyc[0], b_cyc[$] + 1);
    end
    check_stream(tag);
    chk({tag, "_err"}, err, exp_err);
  endtask

  initial begin
    beat_t sb[3];
    bus.i_wr_cmd_req  = 1'b0;
    bus.i_wr_cmd_data = '0;

    // reset state
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_ack",     bus.o_wr_cmd_ack,   0);
    chk("rst_awvalid", bus.m_axi_awvalid,  0);
    chk("rst_wvalid",  bus.m_axi_wvalid,   0);
    chk("rst_bready",  bus.m_axi_bready,   0);
    chk("rst_ready",   bus.o_dma_wr_ready, 0);
    chk("rst_finish",  finish,             0);
    chk("rst_err",     err,                0);
    chk("rst_awsize",  bus.m_axi_awsize,   3);
    chk("rst_awburst", bus.m_axi_awburst,  1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // single burst, no stalls
    stall = 1'b0;
    run_cmd("t1", 32'h1000_0000, 16'h0038, 1'b0);
    // 4 KB page split
    run_cmd("t2", 32'h0000_0FF0, 16'h0040, 1'b0);
    // MAX_BURST split with random back-pressure
    stall = 1'b1;
    run_cmd("t3", 32'h2000_0000, 16'h0100, 1'b0);
    // random commands near page ends, ragged length low bits
    for (int k = 0; k < 4; k++) begin
      logic [31:0] ra;
      logic [15:0] rl;
      ra = {20'($urandom_range(0, 32'hFFFF0)), 12'($urandom_range(3584, 4095))};
      rl = 16'($urandom_range(1, 80) * 8 + $urandom_range(0, 7));
      run_cmd("trand", ra, rl, 1'b0);
    end
    // zero length
    stall = 1'b0;
    run_cmd("t4_len0", 32'h1234_5678, 16'h0000, 1'b0);
    // SLVERR on first of two bursts: still finishes, error sticky
    stall = 1'b1;
    slverr_next = 1'b1;
    run_cmd("t4_slverr", 32'h4000_0F80, 16'h0100, 1'b1);

    // soft reset mid-burst
    stall = 1'b0;
    chk("t5_err_before", err, 1);
    clear_mon();
    for (int k = 0; k < 3; k++) begin
      sb[k].data = {$urandom, $urandom};
      sb[k].keep = 8'($urandom_range(1, 255));
      src_q.push_back(sb[k]);
    end
    @(posedge clk);
    #1;
    bus.i_wr_cmd_req  = 1'b1;
    bus.i_wr_cmd_data = {32'h3000_0000, 16'h0040};
    wait_cnt("t5_ack_timeout", 0, 1, 20);
    @(posedge clk);
    #1;
    bus.i_wr_cmd_req = 1'b0;
    wait_cnt("t5_w3_timeout", 3, 3, 50);
    @(posedge clk);
    #1;
    soft_rst = 1'b1;
    @(posedge clk);
    #1;
    soft_rst = 1'b0;
    chk("t5_ready_drop", bus.o_dma_wr_ready, 0);
    chk("t5_err_clear",  err, 0);
    wait_cnt("t5_b_timeout", 2, 1, 100);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("t5_aw_count", aw_q.size(), 1);
    if (aw_q.size() > 0) chk("t5_awlen", aw_q[0].len, 7);
    chk("t5_w_count", w_q.size(), 8);
    for (int i = 0; i < w_q.size() && i < 8; i++) begin
      chk("t5_wlast", w_q[i].last, (i == 7));
      if (i < 3) begin
        chk("t5_wdata", w_q[i].data, sb[i].data);
        chk("t5_wstrb", w_q[i].strb, sb[i].keep);
      end else begin
        chk("t5_wstrb_null", w_q[i].strb, 0);
      end
    end
    chk("t5_fin_count", fin_cyc.size(), 0);
    chk("t5_err_after", err, 0);
    run_cmd("t5_next", 32'h3000_1000, 16'h0018, 1'b0);

    // req held across the busy period, two commands back to back
    stall = 1'b1;
    clear_mon();
    plan_cmd(32'h5000_0000, 16'h0050);
    plan_cmd(32'h5000_0FE0, 16'h0030);
    @(posedge clk);
    #1;
    bus.i_wr_cmd_req  = 1'b1;
    bus.i_wr_cmd_data = {32'h5000_0000, 16'h0050};
    wait_cnt("t6_ack1_timeout", 0, 1, 20);
    @(posedge clk);
    #1;
    bus.i_wr_cmd_data = {32'h5000_0FE0, 16'h0030};
    wait_cnt("t6_fin1_timeout", 1, 1, 2000);
    wait_cnt("t6_ack2_timeout", 0, 2, 10);
    @(posedge clk);
    #1;
    bus.i_wr_cmd_req = 1'b0;
    wait_cnt("t6_fin2_timeout", 1, 2, 2000);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("t6_ack_count", ack_cyc.size(), 2);
    chk("t6_fin_count", fin_cyc.size(), 2);
    if (ack_cyc.size() > 1 && fin_cyc.size() > 0) chk("t6_ack2_after_fin", ack_cyc[1], fin_cyc[0] + 2);
    check_stream("t6");

    // soft reset while idle clears the sticky error without a finish
    slverr_next = 1'b1;
    run_cmd("t7_err", 32'h6000_0000, 16'h0020, 1'b1);
    clear_mon();
    @(posedge clk);
    #1;
    soft_rst = 1'b1;
    @(posedge clk);
    #1;
    soft_rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t7_err_clear", err, 0);
    chk("t7_no_finish", fin_cyc.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
